// File: rtl/serial_adder.sv
// Bit-serial N-bit adder, LSB first: operands taken in IDLE, result valid N+1 edges later.
// Holds the result in DONE until o_ready; i_valid is ignored while BUSY or DONE.
module serial_adder #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_valid,
   output logic         i_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         c_in,
   output logic         o_valid,
   input  logic         o_ready,
   output logic [N-1:0] sum,
   output logic         c_out,
   output logic         overflow
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt;
   logic           carry;
   logic [N-1:0]   a_sh, b_sh, sum_sh;
   logic           bit_s, carry_nxt, last_bit;

   assign bit_s     = a_sh[0] ^ b_sh[0] ^ carry;
   assign carry_nxt = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
   assign last_bit  = (cnt == LAST);

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (i_valid)  state_nxt = BUSY;
         BUSY:    if (last_bit) state_nxt = DONE;
         DONE:    if (o_ready)  state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         carry    <= 1'b0;
         a_sh     <= '0;
         b_sh     <= '0;
         sum_sh   <= '0;
         c_out    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (i_valid) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= c_in;
                  cnt   <= '0;
               end
            end
            BUSY: begin
               // New sum bit enters at the MSB so after N shifts bit 0 lands at sum[0].
               sum_sh <= (sum_sh >> 1) | (N'(bit_s) << (N - 1));
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               carry  <= carry_nxt;
               cnt    <= cnt + 1'b1;
               if (last_bit) begin
                  c_out    <= carry_nxt;
                  overflow <= carry ^ carry_nxt;
               end
            end
            default: ;
         endcase
      end
   end

   assign i_ready = (state == IDLE);
   assign o_valid = (state == DONE);
   assign sum     = sum_sh;

endmodule
